// File: rtl/uc_stall.sv
// uc_stall: Mealy control unit for the cd datapath. Decode has zero latency. A slow IN read holds the PC (pc_en=0) until rd_ack.
// HALT waits for resume. Optional UC_TIMEOUT_EN aborts a WAIT after WAIT_MAX cycles and sets a sticky err.
module uc_stall #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             rd_ack,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_mux_alu,
  output logic             s_mux_datos,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_en,
  output logic             rd_req,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_IN   = 6'b010000;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_HALT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

`ifdef UC_TIMEOUT_EN
  localparam int            TW       = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  // The counter holds completed no-ack WAIT cycles, so expiry is the cycle that would bring it to WAIT_MAX.
  localparam logic [TW-1:0] TMO_LAST = TW'(WAIT_MAX - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX > 0);
`endif

  always_comb begin
    state_d     = state_q;
    s_inc       = 1'b1;
    s_mux_alu   = 1'b0;
    s_mux_datos = 1'b0;
    we3         = 1'b0;
    wez         = 1'b0;
    op_alu      = 3'b000;
    pc_en       = 1'b1;
    rd_req      = 1'b0;
`ifdef UC_TIMEOUT_EN
    err_d       = err_q;
    tmo_d       = '0;
`endif
    case (state_q)
      ST_RUN: begin
        casez (opcode)
          6'b000???: begin
            op_alu = opcode[2:0];
            we3    = 1'b1;
            wez    = 1'b1;
          end
          6'b001???: begin
            op_alu    = opcode[2:0];
            s_mux_alu = 1'b1;
            we3       = 1'b1;
            wez       = 1'b1;
          end
          OP_IN: begin
            rd_req = 1'b1;
            pc_en  = 1'b0;
            if (rd_ack) begin
              s_mux_datos = 1'b1;
              we3         = 1'b1;
              pc_en       = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
          OP_J:    s_inc = 1'b0;
          OP_JZ:   s_inc = ~z;
          OP_JNZ:  s_inc = z;
          OP_HALT: begin
            pc_en   = 1'b0;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_WAIT: begin
        rd_req = 1'b1;
        pc_en  = 1'b0;
        if (rd_ack) begin
          s_mux_datos = 1'b1;
          we3         = 1'b1;
          pc_en       = 1'b1;
          state_d     = ST_RUN;
        end
`ifdef UC_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          pc_en   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
`endif
      end
      ST_HALT: begin
        pc_en = 1'b0;
        if (resume) begin
          pc_en   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset overrides decode so a read in flight is dropped without write-back.
    if (reset) begin
      state_d     = ST_RUN;
      s_inc       = 1'b1;
      s_mux_alu   = 1'b0;
      s_mux_datos = 1'b0;
      we3         = 1'b0;
      wez         = 1'b0;
      op_alu      = 3'b000;
      pc_en       = 1'b0;
      rd_req      = 1'b0;
    end

    retired_d = retired_q + CNT_W'(pc_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

`ifdef UC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_uc_stall.sv
// Bench for uc_stall: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_uc_stall;

`ifdef UC_TIMEOUT_EN
  localparam int WMAX = 4;
  localparam bit TMO  = 1'b1;
`else
  localparam int WMAX = 255;
  localparam bit TMO  = 1'b0;
`endif
  localparam int CW = 8;

  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_IN   = 6'b010000;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b010001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic          z = 1'b0;
  logic          rd_ack = 1'b0;
  logic          resume = 1'b0;
  logic          s_inc, s_mux_alu, s_mux_datos, we3, wez, pc_en, rd_req, halted, err;
  logic [2:0]    op_alu;
  logic [CW-1:0] retired;

  int checks = 0;
  int failures = 0;

  uc_stall #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .rd_ack(rd_ack), .resume(resume),
    .s_inc(s_inc), .s_mux_alu(s_mux_alu), .s_mux_datos(s_mux_datos), .we3(we3), .wez(wez),
    .op_alu(op_alu), .pc_en(pc_en), .rd_req(rd_req), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Model: where the program is (running, waiting for data, halted) plus counters.
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
  int            m_mode = M_RUN;
  int            m_wait = 0;
  bit            m_err = 1'b0;
  logic [CW-1:0] m_retired = '0;

  // {s_inc, s_mux_alu, s_mux_datos, we3, wez, op_alu[2:0], pc_en, rd_req, halted, err}
  function automatic logic [11:0] ev(input bit si, input bit sa, input bit sd, input bit w3,
                                     input bit wz, input logic [2:0] alu, input bit pe,
                                     input bit rq, input bit h, input bit e);
    return {si, sa, sd, w3, wz, alu, pe, rq, h, e};
  endfunction

  function automatic logic [11:0] outs();
    return {s_inc, s_mux_alu, s_mux_datos, we3, wez, op_alu, pc_en, rd_req, halted, err};
  endfunction

  function automatic logic [11:0] model_out();
    bit si = 1, sa = 0, sd = 0, w3 = 0, wz = 0, pe = 1, rq = 0;
    logic [2:0] alu = 3'b000;
    if (reset) pe = 0;
    else if (m_mode == M_HALT) pe = resume;
    else if (m_mode == M_WAIT || opcode == OP_IN) begin
      rq = 1; pe = 0;
      if (rd_ack) begin sd = 1; w3 = 1; pe = 1; end
      else if (m_mode == M_WAIT && TMO && (m_wait + 1 >= WMAX)) pe = 1;
    end else if (opcode[5:4] == 2'b00) begin
      alu = opcode[2:0]; w3 = 1; wz = 1; sa = opcode[3];
    end else if (opcode == OP_J) si = 0;
    else if (opcode == OP_JZ) si = !z;
    else if (opcode == OP_JNZ) si = z;
    else if (opcode == OP_HALT) pe = 0;
    return ev(si, sa, sd, w3, wz, alu, pe, rq, m_mode == M_HALT, m_err);
  endfunction

  task automatic model_step(input logic [11:0] e);
    if (reset) begin
      m_mode = M_RUN; m_retired = '0; m_err = 0; m_wait = 0;
    end else begin
      if (e[3]) m_retired = m_retired + 1'b1;
      case (m_mode)
        M_RUN: begin
          if (opcode == OP_IN && !rd_ack) begin m_mode = M_WAIT; m_wait = 0; end
          else if (opcode == OP_HALT) m_mode = M_HALT;
        end
        M_WAIT: begin
          if (rd_ack) m_mode = M_RUN;
          else begin
            m_wait++;
            if (TMO && m_wait >= WMAX) begin m_mode = M_RUN; m_err = 1; end
          end
        end
        default: if (resume) m_mode = M_RUN;
      endcase
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic zz, input logic ack,
                       input logic res, input logic rst);
    opcode = op; z = zz; rd_ack = ack; resume = res; reset = rst;
    #2;
  endtask

  task automatic tick();
    model_step(model_out());
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    drive(OP_ADD, 0, 1, 0, 1);
    tick();
    drive(OP_ADD, 0, 1, 0, 1);
    e = ev(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL reset_outs got=%h exp=%h", outs(), e); end
    checks++;
    if (retired !== '0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    tick();
  endtask

  task automatic test_alu();
    logic [11:0] e;
    drive(OP_ADD, 0, 0, 0, 0);
    e = ev(1, 0, 0, 1, 1, 3'b010, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL alu_add got=%h exp=%h", outs(), e); end
    tick();
    checks++;
    if (retired !== 8'd1) begin failures++; $display("FAIL alu_retired got=%0d exp=1", retired); end
    drive(6'b001101, 1, 1, 1, 0);
    e = ev(1, 1, 0, 1, 1, 3'b101, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL alu_imm got=%h exp=%h", outs(), e); end
    tick();
  endtask

  task automatic test_branch();
    logic [5:0] ops[6] = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_J, OP_NOP};
    bit zs[6] = '{1, 0, 1, 0, 0, 1};
    bit sinc_exp[6] = '{0, 1, 1, 0, 0, 1};
    logic [11:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], zs[i], 0, 0, 0);
      e = ev(sinc_exp[i], 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
      checks++;
      if (outs() !== e) begin failures++; $display("FAIL branch_%0d got=%h exp=%h", i, outs(), e); end
      tick();
    end
  endtask

  task automatic test_in_wait();
    logic [11:0] e;
    logic [CW-1:0] r0;
    r0 = retired;
    for (int i = 0; i < 3; i++) begin
      drive(OP_IN, 0, 0, 0, 0);
      e = ev(1, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0);
      checks++;
      if (outs() !== e) begin failures++; $display("FAIL in_wait_%0d got=%h exp=%h", i, outs(), e); end
      tick();
    end
    drive(OP_IN, 0, 1, 0, 0);
    e = ev(1, 0, 1, 1, 0, 3'b000, 1, 1, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL in_ack got=%h exp=%h", outs(), e); end
    tick();
    drive(OP_NOP, 0, 1, 0, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL in_after got=%h exp=%h", outs(), e); end
    checks++;
    if (retired !== r0 + 8'd1) begin failures++; $display("FAIL in_retired got=%0d exp=%0d", retired, r0 + 8'd1); end
    tick();
  endtask

  task automatic test_in_fast();
    logic [11:0] e;
    drive(OP_IN, 1, 1, 0, 0);
    e = ev(1, 0, 1, 1, 0, 3'b000, 1, 1, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL in_fast got=%h exp=%h", outs(), e); end
    tick();
    drive(OP_JZ, 0, 0, 0, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL in_fast_next got=%h exp=%h", outs(), e); end
    tick();
  endtask

  task automatic test_halt();
    logic [11:0] e;
    logic [CW-1:0] r0;
    r0 = retired;
    drive(OP_HALT, 0, 0, 0, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL halt_issue got=%h exp=%h", outs(), e); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(OP_HALT, 0, 1, 0, 0);
      e = ev(1, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0);
      checks++;
      if (outs() !== e) begin failures++; $display("FAIL halt_hold_%0d got=%h exp=%h", i, outs(), e); end
      tick();
    end
    drive(OP_HALT, 0, 0, 1, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL halt_resume got=%h exp=%h", outs(), e); end
    tick();
    drive(OP_NOP, 0, 0, 0, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL halt_run got=%h exp=%h", outs(), e); end
    checks++;
    if (retired !== r0 + 8'd1) begin failures++; $display("FAIL halt_retired got=%0d exp=%0d", retired, r0 + 8'd1); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    logic [11:0] e;
    drive(OP_IN, 0, 0, 0, 0);
    tick();
    drive(OP_IN, 0, 1, 1, 1);
    e = ev(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL rst_wait got=%h exp=%h", outs(), e); end
    tick();
    drive(OP_NOP, 0, 0, 0, 0);
    e = ev(1, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
    checks++;
    if (outs() !== e) begin failures++; $display("FAIL rst_wait_run got=%h exp=%h", outs(), e); end
    checks++;
    if (retired !== '0) begin failures++; $display("FAIL rst_wait_retired got=%0d exp=0", retired); end
    tick();
  endtask

  task automatic test_wrap();
    drive(OP_NOP, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 255; i++) begin
      drive(OP_NOP, 0, 0, 0, 0);
      tick();
    end
    checks++;
    if (retired !== 8'd255) begin failures++; $display("FAIL wrap_max got=%0d exp=255", retired); end
    drive(OP_NOP, 0, 0, 0, 0);
    tick();
    checks++;
    if (retired !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", retired); end
  endtask

`ifdef UC_TIMEOUT_EN
  task automatic test_timeout();
    logic [11:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      drive(OP_NOP, 0, 0, 0, 1);
      tick();
      drive(OP_IN, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        drive(OP_IN, 0, 0, 0, 0);
        e = ev(1, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0);
        checks++;
        if (outs() !== e) begin failures++; $display("FAIL tmo_wait_%0d_%0d got=%h exp=%h", pass, i, outs(), e); end
        tick();
      end
      drive(OP_IN, 0, pass[0], 0, 0);
      e = (pass == 0) ? ev(1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0) : ev(1, 0, 1, 1, 0, 3'b000, 1, 1, 0, 0);
      checks++;
      if (outs() !== e) begin failures++; $display("FAIL tmo_expire_%0d got=%h exp=%h", pass, outs(), e); end
      tick();
      for (int i = 0; i < 3; i++) begin
        drive(OP_NOP, 0, 0, 0, 0);
        checks++;
        if (err !== (pass == 0)) begin failures++; $display("FAIL tmo_err_%0d_%0d got=%b exp=%b", pass, i, err, pass == 0); end
        tick();
      end
    end
    drive(OP_NOP, 0, 0, 0, 1);
    tick();
    drive(OP_NOP, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear got=%b exp=0", err); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [11:0] e;
    logic [5:0]  op;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0: op = {3'b000, 3'($urandom_range(0, 7))};
        1: op = {3'b001, 3'($urandom_range(0, 7))};
        2, 3: op = OP_IN;
        4: op = OP_J;
        5: op = ($urandom_range(0, 1) == 1) ? OP_JZ : OP_JNZ;
        6: op = OP_HALT;
        default: op = 6'($urandom);
      endcase
      drive(op, 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 63) == 0));
      e = model_out();
      checks++;
      if (outs() !== e) begin failures++; $display("FAIL rand_outs_%0d got=%h exp=%h", i, outs(), e); end
      checks++;
      if (retired !== m_retired) begin failures++; $display("FAIL rand_retired_%0d got=%0d exp=%0d", i, retired, m_retired); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_in_wait();
    test_in_fast();
    test_halt();
    test_reset_in_wait();
    test_wrap();
`ifdef UC_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
